mvm_stream_ctrl: RTL

MVM_STREAM_CTRL -- requirements
Module: mvm_stream_ctrl

---
 rtl/mvm_stream_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mvm_stream_ctrl.sv
// Streaming front-end for an MVM engine: loads x vectors and weights one word at a time,
// pulses the engine, waits for its busy window, then drains the result vector word by word.
module mvm_stream_ctrl #(
  parameter int NUM_BIT    = 8,
  parameter int NUM_VECTOR = 4,
  parameter int DIM        = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_BIT-1:0]               in_data,
  output logic [NUM_VECTOR*DIM*NUM_BIT-1:0] x_vectors,
  output logic [NUM_VECTOR*NUM_BIT-1:0]    wts,
  output logic                             mvm_start,
  input  logic                             mvm_isAcc,
  input  logic [DIM*NUM_BIT-1:0]           mvm_y,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_BIT-1:0]               out_data,
  output logic                             out_last,
  output logic [23:0]                      cycle_count,
  output logic                             err
);
  localparam int NX = NUM_VECTOR * DIM;
  localparam int NW = NX + NUM_VECTOR;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int MW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [KW-1:0] K_LAST  = KW'(NW - 1);
  localparam logic [MW-1:0] M_LAST  = MW'(DIM - 1);
  localparam logic [3:0]    TO_LAST = 4'd15;
  localparam logic [23:0]   CC_MAX  = 24'hFFFFFF;

  typedef enum logic [2:0] {LOAD, START, WAIT_RISE, WAIT_FALL, DRAIN} state_t;

  state_t state, state_nxt;
  logic [KW-1:0] k;
  logic [MW-1:0] m;
  logic [3:0]    to_cnt;
  logic [NX-1:0][NUM_BIT-1:0]         x_q;
  logic [NUM_VECTOR-1:0][NUM_BIT-1:0] w_q;
  logic [DIM-1:0][NUM_BIT-1:0]        y_q;
  logic load_fire, out_fire, timeout, capture;

  assign load_fire = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign timeout   = (state == WAIT_RISE) && !mvm_isAcc && (to_cnt == TO_LAST);
  assign capture   = (state == WAIT_FALL) && !mvm_isAcc;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mvm_start = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      LOAD: begin
        // Reset forces LOAD asynchronously, so gate ready to keep it low during reset.
        in_ready = ~rst;
        if (in_valid && k == K_LAST) state_nxt = START;
      end
      START: begin
        mvm_start = 1'b1;
        state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (mvm_isAcc)    state_nxt = WAIT_FALL;
        else if (timeout) state_nxt = LOAD;
      end
      WAIT_FALL: begin
        if (!mvm_isAcc) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && m == M_LAST) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      k           <= '0;
      m           <= '0;
      to_cnt      <= '0;
      err         <= 1'b0;
      cycle_count <= '0;
      y_q         <= '0;
    end else begin
      state <= state_nxt;
      if (load_fire) k <= (k == K_LAST) ? '0 : k + 1'b1;
      if (out_fire)  m <= (m == M_LAST) ? '0 : m + 1'b1;
      to_cnt <= (state == WAIT_RISE) ? to_cnt + 1'b1 : '0;
      if (timeout) err <= 1'b1;
      // Latency window: cleared on the start edge, counts every wait edge incl. capture.
      if (state == START)
        cycle_count <= '0;
      else if ((state == WAIT_RISE || state == WAIT_FALL) && cycle_count != CC_MAX)
        cycle_count <= cycle_count + 1'b1;
      if (capture) y_q <= mvm_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      w_q <= '0;
    end else if (load_fire) begin
      for (int i = 0; i < NX; i++)
        if (k == KW'(i)) x_q[i] <= in_data;
      for (int i = 0; i < NUM_VECTOR; i++)
        if (k == KW'(NX + i)) w_q[i] <= in_data;
    end
  end

  assign x_vectors = x_q;
  assign wts       = w_q;
  assign out_data  = (state == DRAIN) ? y_q[m] : '0;
  assign out_last  = (state == DRAIN) && (m == M_LAST);

endmodule
